// File: rtl/text_pkg.sv
// Shared constants and FSM encoding for the text-mode character fetch path.
package text_pkg;

    localparam int unsigned COLS_DEF   = 80;
    localparam int unsigned ROWS_DEF   = 60;
    localparam int unsigned COL_W_DEF  = 7;
    localparam int unsigned ROW_W_DEF  = 6;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ATTR_W     = DATA_W_DEF - 8;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fill_state_t;

endpackage

// File: rtl/text_area_ram.sv
// Simple dual-port text-area RAM: one write port, one synchronous read-first read port.
module text_area_ram #(
    parameter int unsigned DEPTH = 7680,
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Read sees the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_char_fetch.sv
// Character-cell fetch with vertical scroll, cursor tag, host write port and fill engine.
module text_char_fetch
    import text_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned COL_W  = COL_W_DEF,
    parameter int unsigned ROW_W  = ROW_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_req,
    input  logic [COL_W-1:0]  horz_pos,
    input  logic [ROW_W-1:0]  line_count,
    input  logic [ROW_W-1:0]  scroll_row,
    input  logic              cursor_en,
    input  logic [COL_W-1:0]  cursor_col,
    input  logic [ROW_W-1:0]  cursor_row,
    output logic [7:0]        ascii,
    output logic [DATA_W-9:0] text_color,
    output logic              char_valid,
    output logic              cursor_hit,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_data,
    output logic              clr_busy
);

    localparam int unsigned AW    = ROW_W + COL_W;
    localparam int unsigned DEPTH = ROWS * (2 ** COL_W);

    fill_state_t       state;
    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [DATA_W-1:0] clr_word;

    logic [ROW_W:0]    row_sum_c;
    logic [ROW_W-1:0]  phys_row_c;
    logic              req_oor_c;
    logic              req_hit_c;
    logic [AW-1:0]     rd_addr_c;

    logic              ram_we_c;
    logic [AW-1:0]     ram_waddr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [DATA_W-1:0] rd_data;

    logic              p1_valid, p1_oor, p1_hit;
    logic [AW-1:0]     p1_addr;
    logic              p2_valid, p2_oor, p2_hit;

    // Screen row -> RAM row with scroll wrap; out-of-range requests read address 0.
    always_comb begin
        row_sum_c  = (ROW_W+1)'(line_count) + (ROW_W+1)'(scroll_row);
        phys_row_c = (32'(row_sum_c) >= ROWS) ? ROW_W'(32'(row_sum_c) - ROWS)
                                               : ROW_W'(row_sum_c);
        req_oor_c  = (32'(horz_pos) >= COLS) || (32'(line_count) >= ROWS);
        req_hit_c  = cursor_en && (horz_pos == cursor_col) &&
                     (line_count == cursor_row) && !req_oor_c;
        rd_addr_c  = req_oor_c ? '0 : {phys_row_c, horz_pos};
    end

    // Two-stage read pipe: address register, RAM read, output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid   <= 1'b0;
            p1_oor     <= 1'b0;
            p1_hit     <= 1'b0;
            p1_addr    <= '0;
            p2_valid   <= 1'b0;
            p2_oor     <= 1'b0;
            p2_hit     <= 1'b0;
            ascii      <= '0;
            text_color <= '0;
            char_valid <= 1'b0;
            cursor_hit <= 1'b0;
        end else begin
            p1_valid   <= pix_req;
            p1_oor     <= req_oor_c;
            p1_hit     <= req_hit_c;
            p1_addr    <= rd_addr_c;
            p2_valid   <= p1_valid;
            p2_oor     <= p1_oor;
            p2_hit     <= p1_hit;
            char_valid <= p2_valid;
            if (p2_valid) begin
                ascii      <= p2_oor ? BLANK_CHAR : rd_data[7:0];
                text_color <= p2_oor ? '0 : rd_data[DATA_W-1:8];
                cursor_hit <= p2_hit;
            end
        end
    end

    // Fill engine: row-major sweep of every visible cell, one cell per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            wr_ready <= 1'b1;
            row_cnt  <= '0;
            col_cnt  <= '0;
            clr_word <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_busy <= 1'b1;
                        wr_ready <= 1'b0;
                        row_cnt  <= '0;
                        col_cnt  <= '0;
                        clr_word <= clr_data;
                    end
                end
                ST_CLEAR: begin
                    if (32'(col_cnt) == COLS - 1) begin
                        col_cnt <= '0;
                        if (32'(row_cnt) == ROWS - 1) begin
                            state    <= ST_IDLE;
                            clr_busy <= 1'b0;
                            wr_ready <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end else begin
                        col_cnt <= col_cnt + COL_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write port mux: host in IDLE (out-of-range dropped), fill engine in CLEAR.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = {wr_row, wr_col};
        ram_wdata_c = wr_data;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    ram_we_c = wr_en && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
                end
                ST_CLEAR: begin
                    ram_we_c    = 1'b1;
                    ram_waddr_c = {row_cnt, col_cnt};
                    ram_wdata_c = clr_word;
                end
                default: ram_we_c = 1'b0;
            endcase
        end
    end

    text_area_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .raddr (p1_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_text_char_fetch.sv
// Bench for text_char_fetch: cycle reference model plus directed tables and corner sequences.
module tb_text_char_fetch;

    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic        clk, rst, pix_req, cursor_en, wr_en, clr_start;
    logic [6:0]  horz_pos, cursor_col, wr_col;
    logic [5:0]  line_count, scroll_row, cursor_row, wr_row;
    logic [15:0] wr_data, clr_data;
    logic [7:0]  ascii, text_color;
    logic        char_valid, cursor_hit, wr_ready, clr_busy;

    int errors = 0;
    int checks = 0;

    text_char_fetch dut (
        .clk(clk), .rst(rst), .pix_req(pix_req), .horz_pos(horz_pos),
        .line_count(line_count), .scroll_row(scroll_row), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .ascii(ascii),
        .text_color(text_color), .char_valid(char_valid), .cursor_hit(cursor_hit),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr_start(clr_start), .clr_data(clr_data),
        .clr_busy(clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: text area as a 2-D array, requests as a two-entry delay line.
    logic [15:0] mem [ROWS][COLS];
    bit          clearing;
    int          clr_idx;
    logic [15:0] clr_word_m;

    typedef struct { bit v; bit oor; bit hit; int row; int col; } req_t;
    req_t        s1;
    bit          s2_v, s2_hit;
    logic [7:0]  s2_a, s2_c;
    logic [7:0]  exp_ascii, exp_color;
    logic        exp_valid, exp_hit, exp_busy, exp_ready;

    task automatic model_edge();
        logic [15:0] w;
        if (rst) begin
            s1.v = 0; s2_v = 0; clearing = 0;
            exp_ascii = 0; exp_color = 0; exp_valid = 0; exp_hit = 0;
            exp_busy = 0; exp_ready = 1;
            return;
        end
        if (s2_v) begin
            exp_ascii = s2_a; exp_color = s2_c; exp_hit = s2_hit;
        end
        exp_valid = s2_v;
        s2_v = s1.v;
        if (s1.v) begin
            if (s1.oor) begin
                s2_a = 8'h20; s2_c = 8'h00; s2_hit = 0;
            end else begin
                w = mem[s1.row][s1.col];
                s2_a = w[7:0]; s2_c = w[15:8]; s2_hit = s1.hit;
            end
        end
        s1.v   = pix_req;
        s1.oor = (int'(horz_pos) >= COLS) || (int'(line_count) >= ROWS);
        s1.col = int'(horz_pos);
        s1.row = s1.oor ? 0 : (int'(line_count) + int'(scroll_row)) % ROWS;
        s1.hit = !s1.oor && cursor_en && (horz_pos == cursor_col) && (line_count == cursor_row);
        if (clearing) begin
            mem[clr_idx / COLS][clr_idx % COLS] = clr_word_m;
            clr_idx++;
            if (clr_idx == ROWS * COLS) clearing = 0;
        end else begin
            if (wr_en && int'(wr_col) < COLS && int'(wr_row) < ROWS)
                mem[int'(wr_row)][int'(wr_col)] = wr_data;
            if (clr_start) begin
                clearing = 1; clr_idx = 0; clr_word_m = clr_data;
            end
        end
        exp_busy  = clearing;
        exp_ready = !clearing;
    endtask

    task automatic check_all();
        checks++;
        if ({ascii, text_color, char_valid, cursor_hit, clr_busy, wr_ready} !==
            {exp_ascii, exp_color, exp_valid, exp_hit, exp_busy, exp_ready}) begin
            errors++;
            $display("FAIL model t=%0t got a=%h c=%h v=%b h=%b busy=%b rdy=%b want a=%h c=%h v=%b h=%b busy=%b rdy=%b",
                     $time, ascii, text_color, char_valid, cursor_hit, clr_busy, wr_ready,
                     exp_ascii, exp_color, exp_valid, exp_hit, exp_busy, exp_ready);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic write_cell(input int row, input int col, input logic [15:0] d);
        wr_en = 1; wr_row = 6'(row); wr_col = 7'(col); wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic check_cell(input string name, input int line, input int col, input logic [15:0] want);
        pix_req = 1; line_count = 6'(line); horz_pos = 7'(col); scroll_row = 0; cursor_en = 0;
        step();
        pix_req = 0;
        step();
        step();
        check_eq(name, {16'h0, text_color, ascii}, {16'h0, want});
    endtask

    typedef struct {
        int col; int line; int scroll; bit cen; int ccol; int crow;
        logic [7:0] a; logic [7:0] c; bit hit;
    } vec_t;
    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] seq_a [4];
        logic [7:0] seq_c [4];

        tbl[0]  = '{5, 3, 0, 0, 0, 0, 8'h41, 8'h1E, 0};
        tbl[1]  = '{7, 3, 58, 0, 0, 0, 8'h42, 8'h21, 0};
        tbl[2]  = '{7, 1, 58, 0, 0, 0, 8'h43, 8'h33, 0};
        tbl[3]  = '{10, 2, 7, 1, 10, 2, 8'h44, 8'h44, 1};
        tbl[4]  = '{11, 2, 7, 1, 10, 2, 8'h20, 8'h07, 0};
        tbl[5]  = '{10, 3, 7, 1, 10, 2, 8'h20, 8'h07, 0};
        tbl[6]  = '{10, 2, 7, 0, 10, 2, 8'h44, 8'h44, 0};
        tbl[7]  = '{79, 60, 0, 0, 0, 0, 8'h20, 8'h00, 0};
        tbl[8]  = '{80, 0, 0, 1, 80, 0, 8'h20, 8'h00, 0};
        tbl[9]  = '{79, 0, 0, 0, 0, 0, 8'h45, 8'h55, 0};
        tbl[10] = '{127, 63, 59, 0, 0, 0, 8'h20, 8'h00, 0};
        tbl[11] = '{79, 59, 1, 0, 0, 0, 8'h45, 8'h55, 0};
        tbl[12] = '{7, 0, 59, 0, 0, 0, 8'h43, 8'h33, 0};

        rst = 1; pix_req = 0; horz_pos = 0; line_count = 0; scroll_row = 0;
        cursor_en = 0; cursor_col = 0; cursor_row = 0; wr_en = 0; wr_col = 0;
        wr_row = 0; wr_data = 0; clr_start = 0; clr_data = 0;
        s1.v = 0; s2_v = 0; clearing = 0;
        @(negedge clk);
        repeat (3) step();
        check_eq("rst_outputs", {ascii, text_color, 8'h0, 5'h0, char_valid, cursor_hit, clr_busy},
                 32'h0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'h1);
        rst = 0;
        step();

        // Full fill; host writes and a second clr_start during the sweep are ignored.
        clr_data = 16'h0720; clr_start = 1;
        step();
        clr_start = 0;
        wr_en = 1; wr_row = 2; wr_col = 3; wr_data = 16'hBEEF;
        n = 0;
        while (clr_busy === 1'b1 && n < 6000) begin
            n++;
            if (n == 10) begin
                clr_start = 1; clr_data = 16'h1234;
            end else begin
                clr_start = 0;
            end
            check_eq("clear_wr_ready_low", 32'(wr_ready), 32'h0);
            step();
        end
        wr_en = 0; clr_start = 0;
        check_eq("clear_cycles", n, 4800);
        check_eq("clear_wr_ready_back", 32'(wr_ready), 32'h1);

        n = 0;
        for (int idx = 0; idx < 4802; idx++) begin
            pix_req = (idx < 4800);
            line_count = 6'(idx / COLS); horz_pos = 7'(idx % COLS); scroll_row = 0;
            step();
            if (idx >= 2 && ({char_valid, text_color, ascii} !== {1'b1, 16'h0720})) n++;
        end
        pix_req = 0;
        check_eq("clear_sweep_bad_cells", n, 0);

        write_cell(3, 5, 16'h1E41);
        write_cell(1, 7, 16'h2142);
        write_cell(59, 7, 16'h3343);
        write_cell(9, 10, 16'h4444);
        write_cell(0, 79, 16'h5545);
        write_cell(60, 5, 16'hFFFF);
        write_cell(3, 80, 16'hFFFF);

        for (int i = 0; i < 13; i++) begin
            pix_req = 1; horz_pos = 7'(tbl[i].col); line_count = 6'(tbl[i].line);
            scroll_row = 6'(tbl[i].scroll); cursor_en = tbl[i].cen;
            cursor_col = 7'(tbl[i].ccol); cursor_row = 6'(tbl[i].crow);
            step();
            pix_req = 0;
            step();
            step();
            check_eq($sformatf("tbl%0d", i), {14'h0, char_valid, cursor_hit, text_color, ascii},
                     {14'h0, 1'b1, tbl[i].hit, tbl[i].c, tbl[i].a});
        end
        cursor_en = 0;

        // Back-to-back requests across the right edge of the text area.
        seq_a[0] = 8'h20; seq_c[0] = 8'h07;
        seq_a[1] = 8'h45; seq_c[1] = 8'h55;
        seq_a[2] = 8'h20; seq_c[2] = 8'h00;
        seq_a[3] = 8'h20; seq_c[3] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            pix_req = (k < 4); horz_pos = 7'(78 + k); line_count = 0; scroll_row = 0;
            step();
            if (k >= 2)
                check_eq($sformatf("edge_col%0d", 76 + k), {15'h0, char_valid, text_color, ascii},
                         {15'h0, 1'b1, seq_c[k-2], seq_a[k-2]});
        end
        pix_req = 0;
        step();
        check_eq("edge_valid_drop", 32'(char_valid), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            pix_req    = ($urandom_range(0, 3) != 0);
            horz_pos   = 7'($urandom_range(0, 127));
            line_count = 6'($urandom_range(0, 63));
            scroll_row = 6'($urandom_range(0, ROWS - 1));
            cursor_en  = ($urandom_range(0, 1) == 1);
            cursor_col = ($urandom_range(0, 2) == 0) ? horz_pos : 7'($urandom_range(0, 127));
            cursor_row = ($urandom_range(0, 2) == 0) ? line_count : 6'($urandom_range(0, 63));
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_col     = 7'($urandom_range(0, 127));
            wr_row     = 6'($urandom_range(0, 63));
            wr_data    = 16'($urandom);
            clr_start  = ($urandom_range(0, 1499) == 0);
            clr_data   = 16'($urandom);
            step();
        end
        pix_req = 0; wr_en = 0; clr_start = 0; cursor_en = 0;
        n = 0;
        while (clr_busy === 1'b1 && n < 6000) begin
            n++;
            step();
        end
        check_eq("random_clear_done", 32'(clr_busy), 32'h0);

        // Reset after 100 fill writes leaves the rest of the area untouched.
        write_cell(1, 19, 16'h1111);
        write_cell(1, 20, 16'hABCD);
        clr_data = 16'h0F30; clr_start = 1;
        step();
        clr_start = 0;
        repeat (100) step();
        rst = 1;
        step();
        rst = 0;
        check_eq("rst_mid_clear_busy", 32'(clr_busy), 32'h0);
        check_eq("rst_mid_clear_ready", 32'(wr_ready), 32'h1);
        check_cell("partial_r0c0", 0, 0, 16'h0F30);
        check_cell("partial_r0c79", 0, 79, 16'h0F30);
        check_cell("partial_r1c19", 1, 19, 16'h0F30);
        check_cell("partial_r1c20", 1, 20, 16'hABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
